// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state encoding and control-word bit positions
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_e;

    localparam int IC4_BIT  = 0;
    localparam int SNGL_BIT = 1;
    localparam int LTIM_BIT = 3;
    localparam int D4_BIT   = 4;
    localparam int D3_BIT   = 3;
    localparam int RIS_BIT  = 0;
    localparam int RR_BIT   = 1;
    localparam int P_BIT    = 2;
    localparam int SMM_BIT  = 5;
    localparam int ESMM_BIT = 6;

    function automatic logic is_icw1(input logic a0, input logic [7:0] d);
        return !a0 && d[D4_BIT];
    endfunction

endpackage

// File: rtl/wr_capture.sv
// rtl/wr_capture.sv - latches CPU write data and flags the commit cycle
module wr_capture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       commit,
    output logic       cmt_a0,
    output logic [7:0] cmt_data
);

    logic       pend_q, pend_d;
    logic       a0_q, a0_d;
    logic [7:0] data_q, data_d;

    // The last low-strobe cycle wins; the write lands once WR_n is seen high.
    always_comb begin
        pend_d = pend_q;
        a0_d   = a0_q;
        data_d = data_q;
        if (!cs_n && !wr_n) begin
            pend_d = 1'b1;
            a0_d   = a0;
            data_d = din;
        end else if (wr_n && pend_q) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            a0_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
            a0_q   <= a0_d;
            data_q <= data_d;
        end
    end

    assign commit   = pend_q && wr_n;
    assign cmt_a0   = a0_q;
    assign cmt_data = data_q;

endmodule

// File: rtl/init_sequencer.sv
// rtl/init_sequencer.sv - ICW initialisation FSM and OCW decode
module init_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       A0,
    input  logic [7:0] InternalD,
    output logic       R,
    output logic       W,
    output logic       init_done,
    output logic [4:0] vec_base,
    output logic [7:0] icw3,
    output logic       sngl,
    output logic       ltim,
    output logic       aeoi,
    output logic [7:0] imr,
    output logic       ocw2_stb,
    output logic [7:0] ocw2_cmd,
    output logic       read_isr,
    output logic       poll_stb,
    output logic       smm
);

    logic       commit;
    logic       cmt_a0;
    logic [7:0] cmt_d;

    wr_capture u_wr_capture (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (CS_n),
        .wr_n     (WR_n),
        .a0       (A0),
        .din      (InternalD),
        .commit   (commit),
        .cmt_a0   (cmt_a0),
        .cmt_data (cmt_d)
    );

    pic_state_e state_q, state_d;
    logic       r_q, r_d, w_q, w_d;
    logic       ic4_q, ic4_d;
    logic [4:0] vec_base_q, vec_base_d;
    logic [7:0] icw3_q, icw3_d;
    logic       sngl_q, sngl_d, ltim_q, ltim_d, aeoi_q, aeoi_d;
    logic [7:0] imr_q, imr_d;
    logic       ocw2_stb_q, ocw2_stb_d;
    logic [7:0] ocw2_cmd_q, ocw2_cmd_d;
    logic       read_isr_q, read_isr_d;
    logic       poll_stb_q, poll_stb_d;
    logic       smm_q, smm_d;

    always_comb begin
        state_d    = state_q;
        ic4_d      = ic4_q;
        vec_base_d = vec_base_q;
        icw3_d     = icw3_q;
        sngl_d     = sngl_q;
        ltim_d     = ltim_q;
        aeoi_d     = aeoi_q;
        imr_d      = imr_q;
        ocw2_stb_d = 1'b0;
        ocw2_cmd_d = ocw2_cmd_q;
        read_isr_d = read_isr_q;
        poll_stb_d = 1'b0;
        smm_d      = smm_q;

        // Simultaneous RD/WR is treated as no transfer on the data buffer.
        r_d = !(!CS_n && !RD_n && WR_n);
        w_d = !(!CS_n && !WR_n && RD_n);

        if (commit) begin
            if (is_icw1(cmt_a0, cmt_d)) begin
                sngl_d     = cmt_d[SNGL_BIT];
                ltim_d     = cmt_d[LTIM_BIT];
                ic4_d      = cmt_d[IC4_BIT];
                imr_d      = 8'h00;
                smm_d      = 1'b0;
                read_isr_d = 1'b0;
                aeoi_d     = 1'b0;
                state_d    = ST_WAIT_ICW2;
            end else begin
                unique case (state_q)
                    ST_WAIT_ICW2: if (cmt_a0) begin
                        vec_base_d = cmt_d[7:3];
                        if (!sngl_q)    state_d = ST_WAIT_ICW3;
                        else if (ic4_q) state_d = ST_WAIT_ICW4;
                        else            state_d = ST_READY;
                    end
                    ST_WAIT_ICW3: if (cmt_a0) begin
                        icw3_d  = cmt_d;
                        state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end
                    ST_WAIT_ICW4: if (cmt_a0) begin
                        aeoi_d  = cmt_d[1];
                        state_d = ST_READY;
                    end
                    ST_READY: begin
                        if (cmt_a0) begin
                            imr_d = cmt_d;
                        end else if (!cmt_d[D3_BIT]) begin
                            ocw2_cmd_d = cmt_d;
                            ocw2_stb_d = 1'b1;
                        end else begin
                            if (cmt_d[RR_BIT])   read_isr_d = cmt_d[RIS_BIT];
                            if (cmt_d[ESMM_BIT]) smm_d      = cmt_d[SMM_BIT];
                            if (cmt_d[P_BIT])    poll_stb_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            r_q        <= 1'b1;
            w_q        <= 1'b1;
            ic4_q      <= 1'b0;
            vec_base_q <= 5'h00;
            icw3_q     <= 8'h00;
            sngl_q     <= 1'b0;
            ltim_q     <= 1'b0;
            aeoi_q     <= 1'b0;
            imr_q      <= 8'h00;
            ocw2_stb_q <= 1'b0;
            ocw2_cmd_q <= 8'h00;
            read_isr_q <= 1'b0;
            poll_stb_q <= 1'b0;
            smm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            w_q        <= w_d;
            ic4_q      <= ic4_d;
            vec_base_q <= vec_base_d;
            icw3_q     <= icw3_d;
            sngl_q     <= sngl_d;
            ltim_q     <= ltim_d;
            aeoi_q     <= aeoi_d;
            imr_q      <= imr_d;
            ocw2_stb_q <= ocw2_stb_d;
            ocw2_cmd_q <= ocw2_cmd_d;
            read_isr_q <= read_isr_d;
            poll_stb_q <= poll_stb_d;
            smm_q      <= smm_d;
        end
    end

    assign R         = r_q;
    assign W         = w_q;
    assign init_done = (state_q == ST_READY);
    assign vec_base  = vec_base_q;
    assign icw3      = icw3_q;
    assign sngl      = sngl_q;
    assign ltim      = ltim_q;
    assign aeoi      = aeoi_q;
    assign imr       = imr_q;
    assign ocw2_stb  = ocw2_stb_q;
    assign ocw2_cmd  = ocw2_cmd_q;
    assign read_isr  = read_isr_q;
    assign poll_stb  = poll_stb_q;
    assign smm       = smm_q;

endmodule

// File: tb/tb_init_sequencer.sv
// tb/tb_init_sequencer.sv - scoreboard bench for init_sequencer
module tb_init_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       CS_n, RD_n, WR_n, A0;
    logic [7:0] InternalD;
    logic       R, W, init_done, sngl, ltim, aeoi, ocw2_stb, read_isr, poll_stb, smm;
    logic [4:0] vec_base;
    logic [7:0] icw3, imr, ocw2_cmd;

    init_sequencer dut (
        .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A0(A0),
        .InternalD(InternalD), .R(R), .W(W), .init_done(init_done),
        .vec_base(vec_base), .icw3(icw3), .sngl(sngl), .ltim(ltim), .aeoi(aeoi),
        .imr(imr), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd), .read_isr(read_isr),
        .poll_stb(poll_stb), .smm(smm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       r, w, done;
        logic [4:0] vec;
        logic [7:0] icw3;
        logic       sngl, ltim, aeoi;
        logic [7:0] imr;
        logic       o2stb;
        logic [7:0] cmd;
        logic       risr, pstb, smm;
    } snap_t;

    typedef struct {
        int    due;
        snap_t s;
        string name;
    } entry_t;

    entry_t sbq[$];
    int     n_pass = 0;
    int     n_total = 0;
    bit     end_req = 1'b0;

    // Reference model: ICW1 builds the list of words still owed before the
    // device is configured; once the list is empty, writes are OCWs.
    bit       m_cfg, m_sngl, m_ltim, m_ic4, m_aeoi, m_risr, m_smm, m_o2stb, m_pstb;
    bit [4:0] m_vec;
    bit [7:0] m_icw3, m_imr, m_cmd;
    int       m_todo[$];

    function automatic void m_reset();
        m_cfg = 0; m_sngl = 0; m_ltim = 0; m_ic4 = 0; m_aeoi = 0; m_risr = 0;
        m_smm = 0; m_o2stb = 0; m_pstb = 0; m_vec = 0; m_icw3 = 0; m_imr = 0; m_cmd = 0;
        m_todo.delete();
    endfunction

    function automatic void m_apply(input bit a0, input bit [7:0] d);
        int step;
        if (!a0 && d[4]) begin
            m_sngl = d[1]; m_ltim = d[3]; m_ic4 = d[0];
            m_imr = 0; m_smm = 0; m_risr = 0; m_aeoi = 0;
            m_todo.delete();
            m_todo.push_back(2);
            if (!m_sngl) m_todo.push_back(3);
            if (m_ic4)   m_todo.push_back(4);
            m_cfg = 1;
        end else if (!m_cfg) begin
        end else if (m_todo.size() > 0) begin
            if (a0) begin
                step = m_todo.pop_front();
                if (step == 2)      m_vec  = d[7:3];
                else if (step == 3) m_icw3 = d;
                else                m_aeoi = d[1];
            end
        end else if (a0) begin
            m_imr = d;
        end else if (!d[3]) begin
            m_cmd = d; m_o2stb = 1;
        end else begin
            if (d[1]) m_risr = d[0];
            if (d[6]) m_smm  = d[5];
            if (d[2]) m_pstb = 1;
        end
    endfunction

    function automatic snap_t model_snap(input bit r, input bit w);
        snap_t s;
        s.r = r; s.w = w; s.done = m_cfg && (m_todo.size() == 0);
        s.vec = m_vec; s.icw3 = m_icw3; s.sngl = m_sngl; s.ltim = m_ltim;
        s.aeoi = m_aeoi; s.imr = m_imr; s.o2stb = m_o2stb; s.cmd = m_cmd;
        s.risr = m_risr; s.pstb = m_pstb; s.smm = m_smm;
        return s;
    endfunction

    task automatic expect_now(input bit r, input bit w, input string nm);
        entry_t e;
        e.due = cyc; e.s = model_snap(r, w); e.name = nm;
        sbq.push_back(e);
        m_o2stb = 0; m_pstb = 0;
    endtask

    // Monitor: compares a full output snapshot on each scheduled cycle and
    // requires both strobes low on every other cycle.
    always @(negedge clk) begin
        entry_t e;
        snap_t  act;
        act = '{R, W, init_done, vec_base, icw3, sngl, ltim, aeoi, imr,
                ocw2_stb, ocw2_cmd, read_isr, poll_stb, smm};
        if (end_req) begin
            n_total++;
            if (sbq.size() == 0) n_pass++;
            else $display("FAIL scoreboard_drain actual=%0d pending, required=0", sbq.size());
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            n_total++;
            if (act === e.s) n_pass++;
            else $display("FAIL %s cyc=%0d actual=%h required=%h", e.name, cyc, act, e.s);
        end else begin
            n_total++;
            if ({ocw2_stb, poll_stb} === 2'b00) n_pass++;
            else $display("FAIL idle_strobe cyc=%0d actual=%b required=00", cyc, {ocw2_stb, poll_stb});
        end
    end

    task automatic wr(input bit a0, input bit [7:0] d, input int hold,
                      input bit rd_low, input bit cs_commit, input string nm);
        @(posedge clk); #1;
        CS_n = 0; WR_n = 0; RD_n = !rd_low; A0 = a0; InternalD = d;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            expect_now(1'b1, rd_low, {nm, "_strobe"});
        end
        CS_n = !cs_commit; WR_n = 1; RD_n = 1;
        A0 = $urandom_range(0, 1); InternalD = $urandom_range(0, 255);
        @(posedge clk); #1;
        m_apply(a0, d);
        expect_now(1'b1, 1'b1, nm);
        CS_n = 1;
    endtask

    task automatic rd(input string nm);
        @(posedge clk); #1;
        CS_n = 0; RD_n = 0;
        @(posedge clk); #1;
        expect_now(1'b0, 1'b1, nm);
        CS_n = 1; RD_n = 1;
    endtask

    task automatic pulse_reset(input string nm);
        @(posedge clk); #1;
        rst_n = 0;
        m_reset();
        expect_now(1'b1, 1'b1, nm);
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        bit [7:0] d;
        bit       a0;
        int       op, kind;
        rst_n = 0; CS_n = 1; RD_n = 1; WR_n = 1; A0 = 0; InternalD = 8'h00;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_now(1'b1, 1'b1, "reset_state");
        rst_n = 1;

        wr(0, 8'h13, 1, 0, 0, "single_icw1");
        wr(1, 8'h48, 1, 0, 0, "single_icw2");
        wr(1, 8'h03, 1, 0, 0, "single_icw4");

        wr(0, 8'h11, 1, 0, 0, "casc_icw1");
        wr(1, 8'h20, 2, 0, 1, "casc_icw2");
        wr(1, 8'h04, 1, 0, 0, "casc_icw3");
        wr(1, 8'h01, 1, 0, 0, "casc_icw4");

        wr(1, 8'hA5, 1, 0, 0, "ocw1");
        wr(0, 8'h20, 1, 0, 0, "ocw2");
        wr(0, 8'h0B, 1, 0, 0, "ocw3_rr");
        wr(0, 8'h6C, 1, 0, 0, "ocw3_smm_poll");

        wr(0, 8'h10, 1, 0, 0, "reinit_icw1");
        wr(1, 8'h30, 1, 0, 0, "reinit_icw2");
        wr(0, 8'h08, 1, 0, 0, "ocw_in_wait_ignored");
        wr(0, 8'h10, 3, 0, 0, "icw1_in_wait3");

        rd("read_dir");
        wr(0, 8'h18, 1, 1, 0, "rd_wr_both_low");
        pulse_reset("reset_in_wait2");
        wr(1, 8'h55, 1, 0, 0, "a0_write_after_reset");
        wr(0, 8'h0C, 1, 0, 0, "ocw_in_idle_ignored");

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 99);
            if (op < 2) begin
                pulse_reset("rand_reset");
            end else if (op < 12) begin
                rd("rand_read");
            end else if (op < 20) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end else begin
                kind = $urandom_range(0, 9);
                d = $urandom_range(0, 255);
                a0 = $urandom_range(0, 1);
                if (kind < 2)      begin a0 = 0; d[4] = 1; end
                else if (kind < 4) begin a0 = 0; d[4] = 0; d[3] = 0; end
                else if (kind < 6) begin a0 = 0; d[4] = 0; d[3] = 1; end
                wr(a0, d, $urandom_range(1, 3), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 1), "rand_write");
            end
        end

        repeat (3) @(posedge clk);
        #1;
        end_req = 1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
